// File: rtl/vga_pkg.sv
// Shared VGA pixel-path types and constants: active-area defaults, colour struct,
// FSM and direction enums.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COL_WHITE   = 24'hFFFFFF;
  localparam rgb_t COL_BLACK   = 24'h000000;
  localparam rgb_t COL_BOX_DEF = 24'h960000;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    STEP_X,
    STEP_Y
  } state_t;

  typedef enum logic {
    DIR_POS,
    DIR_NEG
  } dir_t;

endpackage

// File: rtl/box_pixel_source_if.sv
// Video bus between the sync generator / VGA controller and the pixel source:
// counters and visible flag in, registered colour and frame pulse out.
interface box_pixel_source_if;
  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       blank;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       frame_tick;

  modport master (output cnt_h, cnt_v, blank, input r, g, b, frame_tick);
  modport slave  (input cnt_h, cnt_v, blank, output r, g, b, frame_tick);
endinterface

// File: rtl/box_axis_step.sv
// One axis of box motion: advance pos by spd in dir, clamping at 0 / limit and
// bouncing (flipping dir) when an edge is reached.
module box_axis_step
  import vga_pkg::*;
(
  input  logic [9:0] pos,
  input  dir_t       dir,
  input  logic [2:0] spd,
  input  logic [9:0] limit,
  output logic [9:0] pos_next,
  output dir_t       dir_next
);

  logic [10:0] sum;

  // 11-bit sum so a position near the far edge cannot wrap past zero
  assign sum = {1'b0, pos} + {8'b0, spd};

  always_comb begin
    pos_next = pos;
    dir_next = dir;
    if (spd != 3'd0) begin
      if (dir == DIR_POS) begin
        if (sum >= {1'b0, limit}) begin
          pos_next = limit;
          dir_next = DIR_NEG;
        end else begin
          pos_next = sum[9:0];
        end
      end else begin
        if ({1'b0, pos} <= {8'b0, spd}) begin
          pos_next = 10'd0;
          dir_next = DIR_POS;
        end else begin
          pos_next = pos - {7'b0, spd};
        end
      end
    end
  end

endmodule

// File: rtl/box_pixel_source.sv
// Bouncing-box pixel source: background with a one-pixel black border and a moving
// square, double-buffered colours committed once per frame, one-clock output latency.
module box_pixel_source
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  box_pixel_source_if.slave        vid,
  input  logic                     enable,
  input  logic [2:0]               speed,
  input  logic                     col_we,
  input  logic                     col_sel,
  input  logic [23:0]              col_data
);

  localparam logic [9:0] X_LIMIT = 10'(H_ACTIVE - BOX);
  localparam logic [9:0] Y_LIMIT = 10'(V_ACTIVE - BOX);
  localparam logic [9:0] X_INIT  = 10'((H_ACTIVE - BOX) / 2);
  localparam logic [9:0] Y_INIT  = 10'((V_ACTIVE - BOX) / 2);

  state_t     state_reg, state_next;
  logic [9:0] box_x_reg, box_y_reg;
  dir_t       dir_x_reg, dir_y_reg;
  logic [2:0] spd_q_reg;
  rgb_t       bg_act_reg, bg_shd_reg, box_act_reg, box_shd_reg;
  rgb_t       pix_reg, pix_next;
  logic       frame_tick_reg;

  logic [9:0] x_pos_next, y_pos_next;
  dir_t       x_dir_next, y_dir_next;
  logic       tick_cond, in_box, on_border;

  assign tick_cond = (vid.cnt_h == 10'(H_ACTIVE)) && (vid.cnt_v == 10'(V_ACTIVE));

  box_axis_step u_step_x (
    .pos(box_x_reg), .dir(dir_x_reg), .spd(spd_q_reg), .limit(X_LIMIT),
    .pos_next(x_pos_next), .dir_next(x_dir_next)
  );

  box_axis_step u_step_y (
    .pos(box_y_reg), .dir(dir_y_reg), .spd(spd_q_reg), .limit(Y_LIMIT),
    .pos_next(y_pos_next), .dir_next(y_dir_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_FRAME: if (tick_cond && enable) state_next = STEP_X;
      STEP_X:     state_next = STEP_Y;
      STEP_Y:     state_next = WAIT_FRAME;
      default:    state_next = WAIT_FRAME;
    endcase
  end

  always_comb begin
    in_box = ({1'b0, vid.cnt_h} >= {1'b0, box_x_reg}) &&
             ({1'b0, vid.cnt_h} <  ({1'b0, box_x_reg} + 11'(BOX))) &&
             ({1'b0, vid.cnt_v} >= {1'b0, box_y_reg}) &&
             ({1'b0, vid.cnt_v} <  ({1'b0, box_y_reg} + 11'(BOX)));
    on_border = (vid.cnt_h == 10'd0) || (vid.cnt_h == 10'(H_ACTIVE - 1)) ||
                (vid.cnt_v == 10'd0) || (vid.cnt_v == 10'(V_ACTIVE - 1));
    pix_next = bg_act_reg;
    if (!vid.blank)     pix_next = COL_BLACK;
    else if (in_box)    pix_next = box_act_reg;
    else if (on_border) pix_next = COL_BLACK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= WAIT_FRAME;
      box_x_reg      <= X_INIT;
      box_y_reg      <= Y_INIT;
      dir_x_reg      <= DIR_POS;
      dir_y_reg      <= DIR_POS;
      spd_q_reg      <= 3'd0;
      bg_act_reg     <= COL_WHITE;
      bg_shd_reg     <= COL_WHITE;
      box_act_reg    <= COL_BOX_DEF;
      box_shd_reg    <= COL_BOX_DEF;
      pix_reg        <= COL_BLACK;
      frame_tick_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pix_reg        <= pix_next;
      frame_tick_reg <= tick_cond;
      if (col_we && !col_sel) bg_shd_reg  <= col_data;
      if (col_we && col_sel)  box_shd_reg <= col_data;
      // A write landing on the tick bypasses the shadow so it is not a frame late
      if (tick_cond) begin
        spd_q_reg   <= speed;
        bg_act_reg  <= (col_we && !col_sel) ? rgb_t'(col_data) : bg_shd_reg;
        box_act_reg <= (col_we && col_sel)  ? rgb_t'(col_data) : box_shd_reg;
      end
      if (state_reg == STEP_X) begin
        box_x_reg <= x_pos_next;
        dir_x_reg <= x_dir_next;
      end
      if (state_reg == STEP_Y) begin
        box_y_reg <= y_pos_next;
        dir_y_reg <= y_dir_next;
      end
    end
  end

  assign vid.r          = pix_reg.r;
  assign vid.g          = pix_reg.g;
  assign vid.b          = pix_reg.b;
  assign vid.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_box_pixel_source.sv
// Directed bench for box_pixel_source: pixel priority, frame tick, box motion and
// bounce, double-buffered colour commit, and asynchronous reset mid-step.
module tb_box_pixel_source;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  speed;
  logic        col_we;
  logic        col_sel;
  logic [23:0] col_data;
  int          checks = 0;
  int          errors = 0;

  box_pixel_source_if vif ();

  box_pixel_source #(.H_ACTIVE(640), .V_ACTIVE(480), .BOX(32)) dut (
    .clk(clk), .reset(reset), .vid(vif), .enable(enable), .speed(speed),
    .col_we(col_we), .col_sel(col_sel), .col_data(col_data)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int h, input int v, input logic bl);
    vif.cnt_h = 10'(h);
    vif.cnt_v = 10'(v);
    vif.blank = bl;
  endtask

  task automatic do_frame(input logic [2:0] spd);
    speed = spd;
    set_px(640, 480, 1'b0);
    step();
    set_px(700, 500, 1'b0);
    repeat (3) step();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; speed = 3'd0;
    col_we = 1'b0; col_sel = 1'b0; col_data = 24'h0;
    set_px(700, 500, 1'b0);
    repeat (3) step();
    check("rst_rgb",   {vif.r, vif.g, vif.b}, 24'h000000);
    check("rst_tick",  vif.frame_tick, 1'b0);
    check("rst_box_x", dut.box_x_reg, 304);
    check("rst_box_y", dut.box_y_reg, 224);
    check("rst_state", dut.state_reg, WAIT_FRAME);
    check("rst_dir_x", dut.dir_x_reg, DIR_POS);

    @(negedge clk) reset = 1'b1;
    set_px(320, 240, 1'b1); step(); check("px_box",     {vif.r, vif.g, vif.b}, 24'h960000);
    set_px(100, 240, 1'b1); step(); check("px_bg",      {vif.r, vif.g, vif.b}, 24'hFFFFFF);
    set_px(320, 240, 1'b0); step(); check("px_blank",   {vif.r, vif.g, vif.b}, 24'h000000);
    set_px(0,   100, 1'b1); step(); check("px_brd_l",   {vif.r, vif.g, vif.b}, 24'h000000);
    set_px(639, 100, 1'b1); step(); check("px_brd_r",   {vif.r, vif.g, vif.b}, 24'h000000);
    set_px(100, 479, 1'b1); step(); check("px_brd_b",   {vif.r, vif.g, vif.b}, 24'h000000);
    set_px(100, 478, 1'b1); step(); check("px_in_b",    {vif.r, vif.g, vif.b}, 24'hFFFFFF);
    set_px(335, 255, 1'b1); step(); check("px_box_br",  {vif.r, vif.g, vif.b}, 24'h960000);
    set_px(336, 255, 1'b1); step(); check("px_box_r+1", {vif.r, vif.g, vif.b}, 24'hFFFFFF);
    set_px(304, 223, 1'b1); step(); check("px_box_t-1", {vif.r, vif.g, vif.b}, 24'hFFFFFF);
    set_px(303, 224, 1'b1); step(); check("px_box_l-1", {vif.r, vif.g, vif.b}, 24'hFFFFFF);

    // one enabled frame at speed 4
    enable = 1'b1; speed = 3'd4;
    set_px(640, 480, 1'b0); step();
    check("tick_hi",   vif.frame_tick, 1'b1);
    check("st_step_x", dut.state_reg, STEP_X);
    check("x_hold_T1", dut.box_x_reg, 304);
    speed = 3'd0;
    set_px(700, 500, 1'b0); step();
    check("tick_lo",   vif.frame_tick, 1'b0);
    check("x_T2",      dut.box_x_reg, 308);
    check("y_hold_T2", dut.box_y_reg, 224);
    step();
    check("y_T3",      dut.box_y_reg, 228);
    check("st_wait",   dut.state_reg, WAIT_FRAME);

    // shadowed box colour write, committed on the next tick
    enable = 1'b0;
    col_we = 1'b1; col_sel = 1'b1; col_data = 24'h00FF00;
    set_px(320, 240, 1'b1); step();
    col_we = 1'b0; step();
    check("col_shadow", {vif.r, vif.g, vif.b}, 24'h960000);
    set_px(640, 480, 1'b0); step();
    check("frozen_x",   dut.box_x_reg, 308);
    check("frozen_st",  dut.state_reg, WAIT_FRAME);
    set_px(320, 240, 1'b1); step();
    check("col_commit", {vif.r, vif.g, vif.b}, 24'h00FF00);

    // write coinciding with the tick commits at once
    col_we = 1'b1; col_sel = 1'b0; col_data = 24'h123456;
    set_px(640, 480, 1'b0); step();
    col_we = 1'b0;
    set_px(100, 100, 1'b1); step();
    check("col_same_tk", {vif.r, vif.g, vif.b}, 24'h123456);

    // back-to-back writes keep the last
    col_we = 1'b1; col_sel = 1'b0; col_data = 24'hAAAAAA; step();
    col_data = 24'h555555; step();
    col_we = 1'b0;
    set_px(640, 480, 1'b0); step();
    set_px(100, 100, 1'b1); step();
    check("col_b2b", {vif.r, vif.g, vif.b}, 24'h555555);

    // bounce at the right edge: 308 + 42*7 = 602, +4 = 606
    enable = 1'b1;
    for (int i = 0; i < 42; i++) do_frame(3'd7);
    do_frame(3'd4);
    check("x_606",    dut.box_x_reg, 606);
    check("dir_606",  dut.dir_x_reg, DIR_POS);
    do_frame(3'd3);
    check("x_608",    dut.box_x_reg, 608);
    check("dir_flip", dut.dir_x_reg, DIR_NEG);
    do_frame(3'd3);
    check("x_605",    dut.box_x_reg, 605);

    // bounce at the left edge: 605 - 86*7 = 3, -1 = 2, then clamp to 0
    for (int i = 0; i < 86; i++) do_frame(3'd7);
    check("x_3",      dut.box_x_reg, 3);
    do_frame(3'd1);
    check("x_2",      dut.box_x_reg, 2);
    do_frame(3'd7);
    check("x_0",      dut.box_x_reg, 0);
    check("dir_pos",  dut.dir_x_reg, DIR_POS);
    do_frame(3'd0);
    check("spd0_x",   dut.box_x_reg, 0);
    check("spd0_dir", dut.dir_x_reg, DIR_POS);

    // asynchronous reset while in STEP_X
    speed = 3'd5;
    set_px(640, 480, 1'b0); step();
    check("pre_rst_st", dut.state_reg, STEP_X);
    #5 reset = 1'b0;
    #1;
    check("arst_x",     dut.box_x_reg, 304);
    check("arst_st",    dut.state_reg, WAIT_FRAME);
    check("arst_rgb",   {vif.r, vif.g, vif.b}, 24'h000000);
    check("arst_tick",  vif.frame_tick, 1'b0);
    @(negedge clk) reset = 1'b1;
    set_px(320, 240, 1'b1); step();
    check("post_box",   {vif.r, vif.g, vif.b}, 24'h960000);
    do_frame(3'd4);
    check("post_x",     dut.box_x_reg, 308);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
